lenet_stream_loader: RTL and testbench

Host-side load engine sitting directly upstream of `lenet5_top`'s loader port. It accepts a 32-bit valid/ready word stream of self-describing packets (header, base address, payload). It converts each packet into the `loader_target_sel` / `loader_wr_en` / `loader_wr_addr` / `loader_wr_data` write sequence expected by the global, weight and bias buffers. For weight and bias targets, it packs `K_CHANNELS` consecutive payload words into one wide lane-parallel write. It also generates the weight-loaded notification that feeds `host_weight_loaded_i`.

---
 rtl/lenet_stream_loader.sv | 138 +++++++++++++
 tb/tb_lenet_stream_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_stream_loader.sv
// lenet_stream_loader: turns a header/base/payload word stream into
// lenet5 loader writes, packing K_CHANNELS words per weight/bias write.
module lenet_stream_loader #(
    parameter int K_CHANNELS = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic [31:0]              s_data_i,
    output logic [1:0]               loader_target_sel_o,
    output logic                     loader_wr_en_o,
    output logic [31:0]              loader_wr_addr_o,
    output logic [K_CHANNELS*32-1:0] loader_wr_data_o,
    output logic                     weight_loaded_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic                     busy_o
);
    localparam int LW = $clog2(K_CHANNELS);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                      state;
    logic                        notify;
    logic [15:0]                 n_writes;
    logic [15:0]                 idx;
    logic [31:0]                 base;
    logic [LW-1:0]               lane;
    logic [K_CHANNELS-1:0][31:0] lanes;
    logic [K_CHANNELS-1:0][31:0] wide;
    logic                        accept;
    logic                        last_write;
    logic                        lane_full;
    logic                        unused_hdr_bits;

    assign accept          = s_valid_i && s_ready_o;
    assign last_write      = (idx + 16'd1) == n_writes;
    assign lane_full       = (loader_target_sel_o == 2'd0) ||
                             (lane == LW'(K_CHANNELS - 1));
    assign unused_hdr_bits = ^s_data_i[28:16];

    // Global-buffer writes carry the word in lane 0 only.
    always_comb begin
        if (loader_target_sel_o == 2'd0) begin
            wide    = '0;
            wide[0] = s_data_i;
        end else begin
            wide                = lanes;
            wide[K_CHANNELS-1]  = s_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state               <= IDLE;
            notify              <= 1'b0;
            n_writes            <= 16'd0;
            idx                 <= 16'd0;
            base                <= 32'd0;
            lane                <= '0;
            lanes               <= '0;
            s_ready_o           <= 1'b0;
            loader_target_sel_o <= 2'd0;
            loader_wr_en_o      <= 1'b0;
            loader_wr_addr_o    <= 32'd0;
            loader_wr_data_o    <= '0;
            weight_loaded_o     <= 1'b0;
            done_o              <= 1'b0;
            err_o               <= 1'b0;
            busy_o              <= 1'b0;
        end else begin
            loader_wr_en_o  <= 1'b0;
            weight_loaded_o <= 1'b0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
            unique case (state)
                IDLE: begin
                    s_ready_o <= 1'b1;
                    if (accept) begin
                        if (s_data_i[31:30] == 2'd3) begin
                            err_o <= 1'b1;
                        end else begin
                            loader_target_sel_o <= s_data_i[31:30];
                            notify              <= s_data_i[29];
                            n_writes            <= s_data_i[15:0];
                            state               <= ADDR;
                            busy_o              <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (accept) begin
                        base  <= s_data_i;
                        idx   <= 16'd0;
                        lane  <= '0;
                        lanes <= '0;
                        if (n_writes == 16'd0) begin
                            state           <= DONE;
                            done_o          <= 1'b1;
                            weight_loaded_o <= notify;
                            s_ready_o       <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        if (lane_full) begin
                            loader_wr_en_o   <= 1'b1;
                            loader_wr_addr_o <= base + {16'h0, idx};
                            loader_wr_data_o <= wide;
                            lanes            <= '0;
                            lane             <= '0;
                            idx              <= idx + 16'd1;
                            if (last_write) begin
                                state           <= DONE;
                                done_o          <= 1'b1;
                                weight_loaded_o <= notify;
                                s_ready_o       <= 1'b0;
                            end
                        end else begin
                            lanes[lane] <= s_data_i;
                            lane        <= lane + LW'(1);
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    s_ready_o <= 1'b1;
                    busy_o    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lenet_stream_loader.sv
// tb_lenet_stream_loader: table-driven packets, directed corner cases and
// randomized traffic, checked every cycle against a packet-level model.
module tb_lenet_stream_loader;
    localparam int K  = 6;
    localparam int DW = K * 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic [1:0]    sel;
    logic          wr_en;
    logic [31:0]   wr_addr;
    logic [DW-1:0] wr_data;
    logic          wl;
    logic          done;
    logic          err;
    logic          busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lenet_stream_loader #(.K_CHANNELS(K)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .s_valid_i           (s_valid),
        .s_ready_o           (s_ready),
        .s_data_i            (s_data),
        .loader_target_sel_o (sel),
        .loader_wr_en_o      (wr_en),
        .loader_wr_addr_o    (wr_addr),
        .loader_wr_data_o    (wr_data),
        .weight_loaded_o     (wl),
        .done_o              (done),
        .err_o               (err),
        .busy_o              (busy)
    );

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] got,
                        input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: parses the accepted word stream packet by packet.
    int            m_phase = 0;
    logic [1:0]    m_tgt;
    logic          m_ntf;
    int            m_n;
    int            m_cnt;
    logic [31:0]   m_base;
    logic [31:0]   m_q[$];
    logic          e_wr = 0, e_done = 0, e_wl = 0, e_err = 0;
    logic          e_ready = 0, e_busy = 0;
    logic [1:0]    e_sel = 0;
    logic [31:0]   e_addr = 0;
    logic [DW-1:0] e_data = '0;

    int            n_wr = 0, n_done = 0, n_err = 0, n_wl = 0;
    logic [31:0]   last_addr = 0;
    logic [DW-1:0] last_data = '0;

    task model_cycle();
        logic go_done;
        int   widx;
        go_done = 1'b0;
        e_wr = 0; e_done = 0; e_wl = 0; e_err = 0;
        if (rst) begin
            m_phase = 0;
            m_q.delete();
            e_sel = 0; e_addr = 0; e_data = '0;
            e_ready = 0; e_busy = 0;
            return;
        end
        if (s_valid && e_ready) begin
            case (m_phase)
                0: begin
                    if (s_data[31:30] == 2'd3) begin
                        e_err = 1;
                    end else begin
                        m_tgt   = s_data[31:30];
                        e_sel   = m_tgt;
                        m_ntf   = s_data[29];
                        m_n     = int'(s_data[15:0]);
                        m_phase = 1;
                    end
                end
                1: begin
                    m_base = s_data;
                    m_cnt  = 0;
                    m_q.delete();
                    if (m_n == 0) go_done = 1;
                    else m_phase = 2;
                end
                default: begin
                    m_cnt++;
                    m_q.push_back(s_data);
                    if (m_tgt == 0 || m_cnt % K == 0) begin
                        widx   = (m_tgt == 0) ? m_cnt - 1 : m_cnt / K - 1;
                        e_wr   = 1;
                        e_addr = m_base + 32'(widx);
                        e_data = '0;
                        foreach (m_q[j]) e_data[j*32 +: 32] = m_q[j];
                        m_q.delete();
                    end
                    if (m_cnt == ((m_tgt == 0) ? m_n : m_n * K)) go_done = 1;
                end
            endcase
            if (go_done) begin
                e_done  = 1;
                e_wl    = m_ntf;
                m_phase = 0;
            end
        end
        e_ready = !go_done;
        e_busy  = go_done || (m_phase != 0);
    endtask

    always @(negedge clk) begin
        chk1("cyc_wr_en", wr_en, e_wr);
        chk1("cyc_done", done, e_done);
        chk1("cyc_weight_loaded", wl, e_wl);
        chk1("cyc_err", err, e_err);
        chk1("cyc_ready", s_ready, e_ready);
        chk1("cyc_busy", busy, e_busy);
        chk32("cyc_sel", 32'(sel), 32'(e_sel));
        chk32("cyc_addr", wr_addr, e_addr);
        chkw("cyc_data", wr_data, e_data);
        if (wr_en) begin
            n_wr++;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (done) n_done++;
        if (err) n_err++;
        if (wl) n_wl++;
        model_cycle();
    end

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_data  = $urandom;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] w);
        int   guard = 0;
        logic acc   = 1'b0;
        s_valid = 1'b1;
        s_data  = w;
        while (!acc) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: word %h not accepted in 50 cycles", w);
                acc = 1'b1;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic send_packet(input logic [31:0] hdr, input logic [31:0] base,
                               input bit has_base, input int npay,
                               input logic [31:0] start, input bit rnd);
        send(hdr);
        if (has_base) begin
            if (rnd && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send(base);
        end
        for (int i = 0; i < npay; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send(rnd ? $urandom : start + 32'(i));
        end
    endtask

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] base;
        bit          has_base;
        int          npay;
        logic [31:0] start;
        int          x_wr;
        int          x_done;
        int          x_err;
        int          x_wl;
        logic [31:0] x_addr;
        logic [31:0] x_lane0;
        logic [31:0] x_lanek;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int          b_wr, b_done, b_err, b_wl;
        logic [1:0]  t;
        logic [15:0] n;
        logic [31:0] b;

        tbl[0] = '{32'h0000_0003, 32'h100, 1'b1, 3, 32'hA,
                   3, 1, 0, 0, 32'h102, 32'hC, 32'h0};
        tbl[1] = '{32'h6000_0002, 32'h20, 1'b1, 12, 32'h1,
                   2, 1, 0, 1, 32'h21, 32'h7, 32'hC};
        tbl[2] = '{32'hC000_0001, 32'h0, 1'b0, 0, 32'h0,
                   0, 0, 1, 0, 32'h0, 32'h0, 32'h0};
        tbl[3] = '{32'h0000_0001, 32'h300, 1'b1, 1, 32'hDEAD_0000,
                   1, 1, 0, 0, 32'h300, 32'hDEAD_0000, 32'h0};
        tbl[4] = '{32'hA000_0001, 32'h40, 1'b1, 6, 32'h11,
                   1, 1, 0, 1, 32'h40, 32'h11, 32'h16};
        tbl[5] = '{32'h2FFF_0002, 32'h7, 1'b1, 2, 32'h55,
                   2, 1, 0, 1, 32'h8, 32'h56, 32'h0};
        tbl[6] = '{32'h8000_0003, 32'h1000, 1'b1, 18, 32'h100,
                   3, 1, 0, 0, 32'h1002, 32'h10C, 32'h111};

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk1("reset_ready", s_ready, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chkw("reset_data", wr_data, '0);
        rst = 1'b0;
        idle(1);
        chk1("ready_after_reset", s_ready, 1'b1);

        foreach (tbl[i]) begin
            b_wr = n_wr; b_done = n_done; b_err = n_err; b_wl = n_wl;
            send_packet(tbl[i].hdr, tbl[i].base, tbl[i].has_base,
                        tbl[i].npay, tbl[i].start, 1'b0);
            idle(3);
            chk32($sformatf("row%0d_writes", i), 32'(n_wr - b_wr), 32'(tbl[i].x_wr));
            chk32($sformatf("row%0d_done", i), 32'(n_done - b_done), 32'(tbl[i].x_done));
            chk32($sformatf("row%0d_err", i), 32'(n_err - b_err), 32'(tbl[i].x_err));
            chk32($sformatf("row%0d_wl", i), 32'(n_wl - b_wl), 32'(tbl[i].x_wl));
            if (tbl[i].x_wr > 0) begin
                chk32($sformatf("row%0d_addr", i), last_addr, tbl[i].x_addr);
                chk32($sformatf("row%0d_lane0", i), last_data[31:0], tbl[i].x_lane0);
                chk32($sformatf("row%0d_lanek", i), last_data[(K-1)*32 +: 32],
                      tbl[i].x_lanek);
            end
        end

        send(32'h8000_0000);
        send(32'h5);
        chk1("zero_done", done, 1'b1);
        chk1("zero_ready_low", s_ready, 1'b0);
        chk1("zero_no_write", wr_en, 1'b0);
        idle(1);
        chk1("zero_ready_back", s_ready, 1'b1);
        chk1("zero_done_clear", done, 1'b0);

        send(32'h0000_0002);
        send(32'hFFFF_FFFF);
        send(32'h1111);
        chk1("wrap_wr0", wr_en, 1'b1);
        chk32("wrap_addr0", wr_addr, 32'hFFFF_FFFF);
        chk32("wrap_data0", wr_data[31:0], 32'h1111);
        idle(1);
        chk1("wrap_bubble_no_wr", wr_en, 1'b0);
        send(32'h2222);
        chk1("wrap_wr1", wr_en, 1'b1);
        chk32("wrap_addr1", wr_addr, 32'h0);
        chk1("wrap_done", done, 1'b1);
        idle(2);

        b_wr = n_wr; b_done = n_done; b_wl = n_wl;
        send(32'h6000_0001);
        send(32'h50);
        for (int i = 0; i < 3; i++) send(32'(i + 1));
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h0000_0001;
        @(posedge clk);
        #1;
        chk1("rst_ready", s_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_sel", 32'(sel), 32'h0);
        chk32("rst_addr", wr_addr, 32'h0);
        chkw("rst_data", wr_data, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        chk32("rst_no_write", 32'(n_wr - b_wr), 32'h0);
        chk32("rst_no_done", 32'(n_done - b_done), 32'h0);
        chk32("rst_no_wl", 32'(n_wl - b_wl), 32'h0);
        send_packet(32'h6000_0001, 32'h60, 1'b1, 6, 32'h21, 1'b0);
        idle(2);
        chk32("post_rst_writes", 32'(n_wr - b_wr), 32'h1);
        chk32("post_rst_addr", last_addr, 32'h60);
        chk32("post_rst_lane0", last_data[31:0], 32'h21);
        chk32("post_rst_lanek", last_data[(K-1)*32 +: 32], 32'h26);

        for (int p = 0; p < 40; p++) begin
            int r;
            r = $urandom_range(0, 9);
            t = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            n = 16'($urandom_range(0, 3));
            b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2))
                                            : $urandom;
            send_packet({t, 1'($urandom), 13'($urandom), n}, b, t != 2'd3,
                        (t == 2'd3) ? 0 : (t == 2'd0) ? int'(n) : int'(n) * K,
                        32'h0, 1'b1);
            idle($urandom_range(0, 2));
        end

        idle(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
